fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter INDEX_BITS, default 4, meaning 2^INDEX_BITS direct-mapped cache lines.
REQ-003 SHALL have parameter WORD_BITS, default 2, meaning 2^WORD_BITS 32-bit words per line.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning fetch start address after reset.
REQ-005 SHALL have port clk  in  1  clock; all state changes on posedge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port ena  in  1  global enable; when low, all state holds.
REQ-008 SHALL have port redirect_valid  in  1  control-flow redirect request.
REQ-009 SHALL have port redirect_pc  in  XLEN  redirect target, word aligned.
REQ-010 SHALL have port flush  in  1  invalidate the entire cache.
REQ-011 SHALL have port dec_valid  out  1  instruction available to decoder.
REQ-012 SHALL have port dec_ready  in  1  decoder accepts the instruction this cycle.
REQ-013 SHALL have ports dec_inst  out  32 and dec_pc  out  XLEN, the instruction and its address.
REQ-014 SHALL have ports mem_req  out  1 (one-cycle read pulse) and mem_addr  out  XLEN.
REQ-015 SHALL have ports mem_ready  in  1 (one-cycle response pulse) and mem_data  in  32.

Function
REQ-016 SHALL split the PC into offset pc[WORD_BITS+1:2], index pc[INDEX_BITS+WORD_BITS+1:WORD_BITS+2], and tag = remaining upper bits.
REQ-017 SHALL implement FSM states RUN and REFILL.
REQ-018 In RUN, SHALL produce a hit when valid[index] is set and tag[index] equals the PC tag.
REQ-019 On a hit with output slot empty or accepted (dec_valid=0 or dec_ready=1), SHALL load dec_inst/dec_pc next cycle, assert dec_valid, and advance pc by 4.
REQ-020 SHALL sustain one instruction per cycle on consecutive hits while dec_ready=1.
REQ-021 SHALL hold dec_valid/dec_inst/dec_pc stable while dec_valid=1 and dec_ready=0.
REQ-022 On a miss in RUN, SHALL enter REFILL with line base = pc with offset bits zeroed.
REQ-023 In REFILL, SHALL issue words 0..2^WORD_BITS-1 in order at mem_addr = base + 4*k, with exactly one request outstanding.
REQ-024 SHALL pulse mem_req one cycle per word, the cycle after entering REFILL or after the previous mem_ready.
REQ-025 On each mem_ready, SHALL write mem_data into the line word k.
REQ-026 After the last word, SHALL set tag and valid for the line, return to RUN, and re-look-up pc (hit on next cycle).
REQ-027 PC SHALL increment modulo 2^XLEN (0xFFFFFFFC + 4 = 0).
REQ-028 redirect_valid SHALL take priority over hit/advance: pc <= redirect_pc, dec_valid cleared next cycle, and any same-cycle handshake is discarded.
REQ-029 A redirect during REFILL SHALL record redirect_pc and let the refill complete normally; fetch resumes at redirect_pc afterwards.
REQ-030 flush SHALL clear all valid bits next cycle.
REQ-031 A flush during REFILL SHALL let outstanding words drain but leave the refilled line invalid.
REQ-032 A mem_ready arriving outside REFILL SHALL be ignored.
REQ-033 When ena=0, SHALL issue no mem_req and leave the state unchanged. mem_ready arriving while ena=0 SHALL still be captured.

Reset
REQ-034 On rst: pc=RESET_PC, state=RUN, all valid bits=0, dec_valid=0, mem_req=0, mem_addr=0, dec_inst=0, dec_pc=0; rst overrides all other inputs.
REQ-035 rst asserted mid-REFILL SHALL abandon the refill, and later mem_ready pulses SHALL be ignored per REQ-032.

Verification
REQ-036 Cold start, RESET_PC=0, memory word n = 0x1000+n, with memory answering 2 cycles after each request -> mem_req for 0x0,0x4,0x8,0xC in order, then dec_valid with inst 0x1000 at pc 0x0, then 0x1001, 0x1002, 0x1003 on consecutive cycles.
REQ-037 Hold dec_ready=0 for 3 cycles with dec_valid=1 -> dec_inst/dec_pc unchanged, pc not advanced, no mem_req.
REQ-038 Redirect to 0x40 on the same cycle as a dec_ready handshake -> next cycle dec_valid=0, then a refill starting at 0x40, then first instruction at dec_pc=0x40.
REQ-039 Redirect to 0x0 during a refill of 0x80 -> all four words of 0x80 are fetched, then a hit at 0x0 with no mem_req.
REQ-040 Flush after line 0 is cached, then refetch 0x0 -> a new refill with 4 mem_req pulses; flush mid-refill -> the same line refills again afterwards.
REQ-041 Redirect to 0xFFFFFFFC -> instructions at 0xFFFFFFFC, then 0x0 (pc wraps).

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with a direct-mapped cache and line refill
module fetch_unit #(
    parameter int XLEN = 32,
    parameter int INDEX_BITS = 4,
    parameter int WORD_BITS = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            flush,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_inst,
    output logic [XLEN-1:0] dec_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [31:0]     mem_data
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << WORD_BITS;
    localparam int IDX_LO   = WORD_BITS + 2;
    localparam int TAG_LO   = INDEX_BITS + WORD_BITS + 2;
    localparam int TAG_BITS = XLEN - TAG_LO;
    localparam int LINE_BITS = XLEN - IDX_LO;
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    typedef enum logic {RUN, REFILL} state_t;
    state_t state, state_next;

    logic [XLEN-1:0]       pc;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [31:0]           lines [LINES*WORDS];

    logic [LINE_BITS-1:0]  base_line;
    logic [WORD_BITS-1:0]  word_cnt;
    logic                  waiting;
    logic                  held_valid;
    logic [31:0]           held_data;
    logic                  redir_pend;
    logic [XLEN-1:0]       redir_pc;
    logic                  flush_pend;
    logic                  req_q;

    logic [WORD_BITS-1:0]  pc_off;
    logic [INDEX_BITS-1:0] pc_idx;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [INDEX_BITS-1:0] base_idx;
    logic [TAG_BITS-1:0]   base_tag;
    logic                  hit;
    logic [31:0]           hit_inst;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic                  last_word;
    logic                  line_we;

    assign pc_off   = pc[IDX_LO-1:2];
    assign pc_idx   = pc[TAG_LO-1:IDX_LO];
    assign pc_tag   = pc[XLEN-1:TAG_LO];
    assign base_idx = base_line[INDEX_BITS-1:0];
    assign base_tag = base_line[LINE_BITS-1:INDEX_BITS];
    assign hit      = valid[pc_idx] && (tags[pc_idx] == pc_tag);
    assign hit_inst = lines[{pc_idx, pc_off}];

    // A response that landed while disabled is replayed from the holding register.
    assign resp_valid = waiting && (held_valid || mem_ready);
    assign resp_data  = held_valid ? held_data : mem_data;
    assign last_word  = &word_cnt;
    assign line_we    = !rst && ena && (state == REFILL) && resp_valid;

    // The request pulse only leaves the block in an enabled cycle.
    assign mem_req = req_q && ena;

    always_comb begin
        state_next = state;
        case (state)
            RUN:    if (!redirect_valid && !hit) state_next = REFILL;
            REFILL: if (resp_valid && last_word) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            valid      <= '0;
            dec_valid  <= 1'b0;
            dec_inst   <= '0;
            dec_pc     <= '0;
            req_q      <= 1'b0;
            mem_addr   <= '0;
            base_line  <= '0;
            word_cnt   <= '0;
            waiting    <= 1'b0;
            held_valid <= 1'b0;
            held_data  <= '0;
            redir_pend <= 1'b0;
            redir_pc   <= '0;
            flush_pend <= 1'b0;
        end else if (!ena) begin
            if (state == REFILL && waiting && mem_ready && !held_valid) begin
                held_valid <= 1'b1;
                held_data  <= mem_data;
            end
        end else begin
            state      <= state_next;
            req_q      <= 1'b0;
            held_valid <= 1'b0;
            if (dec_valid && dec_ready) dec_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        pc        <= redirect_pc;
                        dec_valid <= 1'b0;
                    end else if (hit) begin
                        if (!dec_valid || dec_ready) begin
                            dec_valid <= 1'b1;
                            dec_inst  <= hit_inst;
                            dec_pc    <= pc;
                            pc        <= pc + STEP;
                        end
                    end else begin
                        base_line  <= pc[XLEN-1:IDX_LO];
                        mem_addr   <= {pc[XLEN-1:IDX_LO], {IDX_LO{1'b0}}};
                        req_q      <= 1'b1;
                        waiting    <= 1'b1;
                        word_cnt   <= '0;
                        flush_pend <= 1'b0;
                        redir_pend <= 1'b0;
                    end
                end
                REFILL: begin
                    if (redirect_valid) begin
                        redir_pend <= 1'b1;
                        redir_pc   <= redirect_pc;
                        dec_valid  <= 1'b0;
                    end
                    if (flush) flush_pend <= 1'b1;
                    if (resp_valid) begin
                        if (last_word) begin
                            waiting         <= 1'b0;
                            valid[base_idx] <= !flush_pend;
                            if (redirect_valid) pc <= redirect_pc;
                            else if (redir_pend) pc <= redir_pc;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                            req_q    <= 1'b1;
                            mem_addr <= mem_addr + STEP;
                        end
                    end
                end
                default: ;
            endcase
            if (flush) valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) lines[{base_idx, word_cnt}] <= resp_data;
        if (line_we && last_word) tags[base_idx] <= base_tag;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic        ena;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    fetch_unit dut (
        .clk(clk), .rst(rst), .ena(ena),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } dec_t;

    logic [31:0] exp_req[$];
    dec_t        exp_dec[$];
    int          hs_cyc[$];
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_last = '0;
    logic        spur = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    task automatic push_line(input logic [31:0] base);
        for (int k = 0; k < 4; k++) exp_req.push_back(base + 32'(4 * k));
    endtask

    task automatic push_dec(input logic [31:0] a);
        dec_t d;
        d.pc = a;
        d.inst = word_at(a);
        exp_dec.push_back(d);
    endtask

    // Called at a negedge with inputs settled: model memory, score outputs, advance one cycle.
    task automatic tick();
        logic [31:0] ea;
        dec_t ed;
        mem_ready = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_ready = 1'b1;
                mem_data  = word_at(mem_last);
            end
        end
        if (spur) begin
            mem_ready = 1'b1;
            mem_data  = 32'hDEAD_BEEF;
            spur      = 1'b0;
        end
        if (mem_req) begin
            ea = (exp_req.size() > 0) ? exp_req.pop_front() : 32'hxxxx_xxxx;
            check("mem_addr", mem_addr, ea);
            mem_cnt  = 2;
            mem_last = mem_addr;
        end
        if (dec_valid && dec_ready && !redirect_valid && ena && !rst) begin
            if (exp_dec.size() > 0) begin
                ed = exp_dec.pop_front();
            end else begin
                ed.pc = 32'hxxxx_xxxx;
                ed.inst = 32'hxxxx_xxxx;
            end
            check("dec_pc", dec_pc, ed.pc);
            check("dec_inst", dec_inst, ed.inst);
            hs_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (dec_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(dec_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_req.size() != 0 || exp_dec.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 32'(exp_req.size() + exp_dec.size()), 32'd0);
    endtask

    task automatic redirect(input logic [31:0] target, input logic ready);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        dec_ready      = ready;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        flush = 1'b0; dec_ready = 1'b0; mem_ready = 1'b0; mem_data = '0;
        @(negedge clk);
        tick();
        tick();
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        check("rst_dec_inst", dec_inst, 32'd0);
        rst = 1'b0;

        // Cold start: line 0 refill, four back-to-back hits, then line 1 refill.
        dec_ready = 1'b1;
        hs_cyc.delete();
        push_line(32'h0);
        push_line(32'h10);
        for (int k = 0; k < 4; k++) push_dec(32'(4 * k));
        drain("cold");
        check("cold_hs_count", 32'(hs_cyc.size()), 32'd4);
        for (int k = 1; k < 4 && k < hs_cyc.size(); k++)
            check("cold_b2b", 32'(hs_cyc[k] - hs_cyc[0]), 32'(k));
        dec_ready = 1'b0;

        // Back-pressure: output holds for three cycles.
        wait_valid("stall");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", 32'(dec_valid), 32'd1);
            check("stall_pc", dec_pc, 32'h10);
            check("stall_inst", dec_inst, 32'h1004);
            check("stall_req", 32'(mem_req), 32'd0);
        end
        push_dec(32'h10);
        dec_ready = 1'b1;
        tick();
        check("adv_pc", dec_pc, 32'h14);
        check("adv_inst", dec_inst, 32'h1005);

        // Redirect coincident with a handshake: the handshake is dropped.
        redirect(32'h40, 1'b1);
        dec_ready = 1'b0;
        check("redir_clear", 32'(dec_valid), 32'd0);
        push_line(32'h40);
        wait_valid("redir40");
        check("redir40_pc", dec_pc, 32'h40);
        check("redir40_inst", dec_inst, 32'h1010);
        check("redir40_reqs", 32'(exp_req.size()), 32'd0);

        // Redirect to 0 during the refill of 0x80: refill completes, then hit at 0.
        redirect(32'h80, 1'b0);
        push_line(32'h80);
        for (int k = 0; k < 3; k++) tick();
        redirect(32'h0, 1'b0);
        wait_valid("mid_redir");
        check("mid_redir_pc", dec_pc, 32'h0);
        check("mid_redir_inst", dec_inst, 32'h1000);
        check("mid_redir_reqs", 32'(exp_req.size()), 32'd0);

        // Flush then refetch 0: line 0 refills.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        redirect(32'h0, 1'b0);
        push_line(32'h0);
        wait_valid("flush");
        check("flush_pc", dec_pc, 32'h0);
        check("flush_reqs", 32'(exp_req.size()), 32'd0);

        // Flush during the refill: the line is filled, left invalid, and filled again.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        redirect(32'h0, 1'b0);
        push_line(32'h0);
        push_line(32'h0);
        for (int k = 0; k < 3; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_valid("midflush");
        check("midflush_pc", dec_pc, 32'h0);
        check("midflush_inst", dec_inst, 32'h1000);
        check("midflush_reqs", 32'(exp_req.size()), 32'd0);

        // PC wrap from the top of the address space.
        redirect(32'hFFFF_FFFC, 1'b0);
        push_line(32'hFFFF_FFF0);
        push_dec(32'hFFFF_FFFC);
        push_dec(32'h0);
        dec_ready = 1'b1;
        drain("wrap");
        dec_ready = 1'b0;
        check("wrap_next_pc", dec_pc, 32'h4);
        check("wrap_next_inst", dec_inst, 32'h1001);

        // Enable low while a response arrives: it is kept and the refill resumes.
        redirect(32'h100, 1'b0);
        push_line(32'h100);
        tick();
        tick();
        ena = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ena_req", 32'(mem_req), 32'd0);
            check("ena_valid", 32'(dec_valid), 32'd0);
        end
        ena = 1'b1;
        wait_valid("ena");
        check("ena_pc", dec_pc, 32'h100);
        check("ena_inst", dec_inst, 32'h1040);
        check("ena_reqs", 32'(exp_req.size()), 32'd0);

        // Reset mid-refill: the late response must not land in the cache.
        redirect(32'h200, 1'b0);
        exp_req.push_back(32'h200);
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("midrst_valid", 32'(dec_valid), 32'd0);
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_addr", mem_addr, 32'd0);
        rst = 1'b0;
        push_line(32'h0);
        wait_valid("midrst");
        check("midrst_pc", dec_pc, 32'h0);
        check("midrst_inst", dec_inst, 32'h1000);

        // Spurious response in RUN is ignored.
        spur = 1'b1;
        tick();
        check("spur_pc", dec_pc, 32'h0);
        check("spur_inst", dec_inst, 32'h1000);
        push_dec(32'h0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        check("spur_next_pc", dec_pc, 32'h4);
        check("spur_next_inst", dec_inst, 32'h1001);
        tick();
        check("end_queues", 32'(exp_req.size() + exp_dec.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
